alu_issue_ctrl: RTL and testbench

Execute-stage initiator for the combinational-plus-ready ALU. It accepts one operation at a time from the control unit and drives srcA, srcB and opsel into the ALU. It waits for the ALU's ready, then captures the result and flag_next. It owns the architectural ZNCO flag register, feeds Cflag/Oflag back to the ALU, and emits a one-cycle register-file writeback. A timeout guards against an ALU that never asserts ready.

---
 rtl/alu_issue_ctrl_pkg.sv | 30 +++
 rtl/alu_issue_ctrl_watchdog.sv | 27 ++
 rtl/alu_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opsel codes and flag bit positions used by the ALU and its issue controller.
package alu_issue_ctrl_pkg;

  typedef logic [4:0] opsel_t;
  typedef logic [3:0] flags_t;

  // ALU operation select codes
  localparam opsel_t ALU_ADD     = 5'h00;
  localparam opsel_t ALU_ADC     = 5'h01;
  localparam opsel_t ALU_SUB     = 5'h02;
  localparam opsel_t ALU_SBB     = 5'h03;
  localparam opsel_t ALU_AND     = 5'h04;
  localparam opsel_t ALU_OR      = 5'h05;
  localparam opsel_t ALU_XOR     = 5'h06;
  localparam opsel_t ALU_NOT     = 5'h07;
  localparam opsel_t ALU_SHL     = 5'h08;
  localparam opsel_t ALU_SHR     = 5'h09;
  localparam opsel_t ALU_SAR     = 5'h0A;
  localparam opsel_t ALU_ROL     = 5'h0B;
  localparam opsel_t ALU_ROR     = 5'h0C;
  localparam opsel_t ALU_SHORT_A = 5'h0D;
  localparam opsel_t ALU_SHORT_B = 5'h0E;

  // Flag register bit positions: {Z,N,C,O}
  localparam int ZF = 3;
  localparam int NF = 2;
  localparam int CF = 1;
  localparam int OF = 0;

endpackage

// File: rtl/alu_issue_ctrl_watchdog.sv
// Cycle counter that flags when an ALU operation has waited TIMEOUT cycles for ready.
module alu_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  // Count waiting cycles; clear restarts the window for a new operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst)          count_q <= '0;
    else if (clear_i) count_q <= '0;
    else if (en_i)    count_q <= count_q + 1'b1;
  end

  // The current cycle is the last allowed one once the count sits at TIMEOUT-1.
  assign expire_o = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage initiator: issues one operation to the ready-handshaked ALU,
// captures result and flags, owns the ZNCO flag register and emits writeback.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DW      = 16,
  parameter int DST_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [DW-1:0]    req_a,
  input  logic [DW-1:0]    req_b,
  input  logic [DST_W-1:0] req_dst,
  input  logic             req_setflags,
  input  logic             flags_we,
  input  logic [3:0]       flags_wdata,
  output logic [DW-1:0]    alu_srcA,
  output logic [DW-1:0]    alu_srcB,
  output logic [4:0]       alu_opsel,
  output logic             alu_Cflag,
  output logic             alu_Oflag,
  input  logic [DW-1:0]    alu_res,
  input  logic             alu_ready,
  input  logic [3:0]       alu_flag_next,
  output logic             wb_valid,
  output logic [DST_W-1:0] wb_dst,
  output logic [DW-1:0]    wb_data,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             err_timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic [1:0]       state_q, state_d;
  opsel_t           op_q;
  logic [DW-1:0]    a_q, b_q, res_q;
  logic [DST_W-1:0] dst_q;
  logic             setflags_q;
  flags_t           flags_q, flags_d;
  logic             err_q, err_d;

  logic accept, capture, wd_expire;

  assign accept  = (state_q == ST_IDLE) && req_valid;
  assign capture = (state_q == ST_EXEC) && alu_ready;

  alu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept),
    .en_i     ((state_q == ST_EXEC) && !alu_ready),
    .expire_o (wd_expire)
  );

  // Next-state, timeout pulse and flag-register update selection.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    err_d   = 1'b0;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        if (alu_ready) begin
          state_d = ST_WB;
        end else if (wd_expire) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // ALU capture has priority over an external write landing in the same cycle.
    if (capture && setflags_q) flags_d = alu_flag_next;
    else if (flags_we)         flags_d = flags_wdata;
  end

  // State, request latch, result capture and flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      dst_q      <= '0;
      setflags_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      if (accept) begin
        op_q       <= req_op;
        a_q        <= req_a;
        b_q        <= req_b;
        dst_q      <= req_dst;
        setflags_q <= req_setflags;
      end
      if (capture) res_q <= alu_res;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign alu_opsel   = (state_q == ST_EXEC) ? op_q : ALU_SHORT_B;
  assign alu_srcA    = (state_q == ST_EXEC) ? a_q : '0;
  assign alu_srcB    = (state_q == ST_EXEC) ? b_q : '0;
  assign alu_Cflag   = flags_q[CF];
  assign alu_Oflag   = flags_q[OF];
  assign wb_valid    = (state_q == ST_WB);
  assign wb_dst      = dst_q;
  assign wb_data     = res_q;
  assign flags       = flags_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl; the bench itself plays the ALU.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int DST_W = 3;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_op;
  logic [DW-1:0]    req_a, req_b;
  logic [DST_W-1:0] req_dst;
  logic             req_setflags;
  logic             flags_we;
  logic [3:0]       flags_wdata;
  logic [DW-1:0]    alu_srcA, alu_srcB;
  logic [4:0]       alu_opsel;
  logic             alu_Cflag, alu_Oflag;
  logic [DW-1:0]    alu_res;
  logic             alu_ready;
  logic [3:0]       alu_flag_next;
  logic             wb_valid;
  logic [DST_W-1:0] wb_dst;
  logic [DW-1:0]    wb_data;
  logic [3:0]       flags;
  logic             busy;
  logic             err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DW(DW), .DST_W(DST_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_dst(req_dst), .req_setflags(req_setflags),
    .flags_we(flags_we), .flags_wdata(flags_wdata),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_opsel(alu_opsel),
    .alu_Cflag(alu_Cflag), .alu_Oflag(alu_Oflag),
    .alu_res(alu_res), .alu_ready(alu_ready), .alu_flag_next(alu_flag_next),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .flags(flags), .busy(busy), .err_timeout(err_timeout)
  );

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DST_W-1:0] dst, input logic sf);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_dst = dst; req_setflags = sf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
    checks++; if (alu_opsel !== ALU_SHORT_B) begin errors++; $display("FAIL reset_opsel: got %h expected %h", alu_opsel, ALU_SHORT_B); end
    checks++; if (alu_srcA !== 16'h0000) begin errors++; $display("FAIL reset_srcA: got %h expected 0000", alu_srcA); end
    checks++; if (wb_data !== 16'h0000) begin errors++; $display("FAIL reset_wb_data: got %h expected 0000", wb_data); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    alu_ready = 1'b1; alu_res = 16'h8000; alu_flag_next = 4'b0101;
    present(ALU_ADD, 16'h7FFF, 16'h0001, 3'd3, 1'b1);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL add_accept: got %b expected 1", req_ready); end
    step();  // cycle 1: EXEC
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL add_exec_ready: got %b expected 0", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_exec_busy: got %b expected 1", busy); end
    checks++; if (alu_opsel !== ALU_ADD) begin errors++; $display("FAIL add_opsel: got %h expected %h", alu_opsel, ALU_ADD); end
    checks++; if (alu_srcA !== 16'h7FFF) begin errors++; $display("FAIL add_srcA: got %h expected 7fff", alu_srcA); end
    checks++; if (alu_srcB !== 16'h0001) begin errors++; $display("FAIL add_srcB: got %h expected 0001", alu_srcB); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_early_wb: got %b expected 0", wb_valid); end
    step();  // cycle 2: WB
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_wb_valid: got %b expected 1", wb_valid); end
    checks++; if (wb_data !== 16'h8000) begin errors++; $display("FAIL add_wb_data: got %h expected 8000", wb_data); end
    checks++; if (wb_dst !== 3'd3) begin errors++; $display("FAIL add_wb_dst: got %0d expected 3", wb_dst); end
    checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL add_flags: got %b expected 0101", flags); end
    checks++; if ({alu_Cflag, alu_Oflag} !== 2'b01) begin errors++; $display("FAIL add_CO_feedback: got %b expected 01", {alu_Cflag, alu_Oflag}); end
    step();  // cycle 3: IDLE
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_wb_one_cycle: got %b expected 0", wb_valid); end
    checks++; if (wb_data !== 16'h8000) begin errors++; $display("FAIL add_wb_hold: got %h expected 8000", wb_data); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL add_back_idle: got %b expected 1", req_ready); end
    checks++; if (alu_opsel !== ALU_SHORT_B) begin errors++; $display("FAIL add_idle_opsel: got %h expected %h", alu_opsel, ALU_SHORT_B); end
  endtask

  task automatic test_sub();
    alu_ready = 1'b1; alu_res = 16'h0000; alu_flag_next = 4'b1000;
    present(ALU_SUB, 16'h0005, 16'h0005, 3'd5, 1'b1);
    step(); req_valid = 1'b0;
    step();
    checks++; if (wb_data !== 16'h0000) begin errors++; $display("FAIL sub_wb_data: got %h expected 0000", wb_data); end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL sub_flags: got %b expected 1000", flags); end
    step();
    // Same op without setflags: ALU offers different flags that must be ignored.
    alu_flag_next = 4'b0110;
    present(ALU_SUB, 16'h0005, 16'h0005, 3'd6, 1'b0);
    step(); req_valid = 1'b0;
    step();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL sub_nf_wb_valid: got %b expected 1", wb_valid); end
    checks++; if (wb_dst !== 3'd6) begin errors++; $display("FAIL sub_nf_wb_dst: got %0d expected 6", wb_dst); end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL sub_nf_flags: got %b expected 1000", flags); end
    step();
  endtask

  task automatic test_timeout();
    alu_ready = 1'b0; alu_res = 16'hDEAD; alu_flag_next = 4'b0111;
    present(ALU_XOR, 16'h1111, 16'h2222, 3'd1, 1'b1);
    step(); req_valid = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      checks++; if (busy !== 1'b1 || err_timeout !== 1'b0 || wb_valid !== 1'b0) begin
        errors++; $display("FAIL timeout_wait_%0d: got busy=%b err=%b wb=%b expected busy=1 err=0 wb=0", i, busy, err_timeout, wb_valid);
      end
      step();
    end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b expected 1", err_timeout); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle: got %b expected 1", req_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL timeout_no_wb: got %b expected 0", wb_valid); end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL timeout_flags: got %b expected 1000", flags); end
    step();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_single_pulse: got %b expected 0", err_timeout); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL timeout_late_wb: got %b expected 0", wb_valid); end
  endtask

  task automatic test_ext_flags();
    flags_we = 1'b1; flags_wdata = 4'b0011;
    step(); flags_we = 1'b0;
    checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL ext_idle_flags: got %b expected 0011", flags); end
    checks++; if ({alu_Cflag, alu_Oflag} !== 2'b11) begin errors++; $display("FAIL ext_idle_CO: got %b expected 11", {alu_Cflag, alu_Oflag}); end
    alu_ready = 1'b0; alu_res = 16'h1234;
    present(ALU_AND, 16'hFFFF, 16'h1234, 3'd2, 1'b0);
    step(); req_valid = 1'b0;
    flags_we = 1'b1; flags_wdata = 4'b0010;
    step(); flags_we = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ext_exec_busy: got %b expected 1", busy); end
    checks++; if ({alu_Cflag, alu_Oflag} !== 2'b10) begin errors++; $display("FAIL ext_exec_CO: got %b expected 10", {alu_Cflag, alu_Oflag}); end
    alu_ready = 1'b1;
    step();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h1234) begin
      errors++; $display("FAIL ext_wb: got valid=%b data=%h expected valid=1 data=1234", wb_valid, wb_data);
    end
    checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL ext_final_flags: got %b expected 0010", flags); end
    step();
  endtask

  task automatic test_flag_conflict();
    alu_ready = 1'b0; alu_res = 16'hABCD; alu_flag_next = 4'b1000;
    present(ALU_OR, 16'hA000, 16'h0BCD, 3'd4, 1'b1);
    step(); req_valid = 1'b0;
    alu_ready = 1'b1; flags_we = 1'b1; flags_wdata = 4'b0011;
    step(); flags_we = 1'b0;
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL conflict_flags: got %b expected 1000", flags); end
    checks++; if (wb_data !== 16'hABCD) begin errors++; $display("FAIL conflict_wb_data: got %h expected abcd", wb_data); end
    step();
  endtask

  task automatic test_back_to_back();
    alu_ready = 1'b1; alu_res = 16'h0011; alu_flag_next = 4'b1111;
    present(ALU_ADD, 16'h0111, 16'h0001, 3'd1, 1'b0);
    // cycle 0
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_c0_ready: got %b expected 1", req_ready); end
    step();  // cycle 1
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_c1_ready: got %b expected 0", req_ready); end
    step();  // cycle 2
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h0011 || req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_c2: got wb=%b data=%h ready=%b expected wb=1 data=0011 ready=0", wb_valid, wb_data, req_ready);
    end
    present(ALU_SUB, 16'h0222, 16'h0001, 3'd7, 1'b0);
    alu_res = 16'h0022;
    step();  // cycle 3
    checks++; if (req_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_c3: got ready=%b wb=%b expected ready=1 wb=0", req_ready, wb_valid);
    end
    step();  // cycle 4
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || alu_srcA !== 16'h0222) begin
      errors++; $display("FAIL b2b_c4: got ready=%b srcA=%h expected ready=0 srcA=0222", req_ready, alu_srcA);
    end
    step();  // cycle 5
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h0022 || wb_dst !== 3'd7) begin
      errors++; $display("FAIL b2b_c5: got wb=%b data=%h dst=%0d expected wb=1 data=0022 dst=7", wb_valid, wb_data, wb_dst);
    end
    step();  // cycle 6
    checks++; if (req_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_c6: got ready=%b wb=%b expected ready=1 wb=0", req_ready, wb_valid);
    end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL b2b_flags: got %b expected 1000", flags); end
  endtask

  task automatic test_reset_mid_exec();
    alu_ready = 1'b0; alu_res = 16'h5555; alu_flag_next = 4'b0001;
    present(ALU_ADD, 16'h0001, 16'h0002, 3'd2, 1'b1);
    step(); req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstx_exec_busy: got %b expected 1", busy); end
    rst = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rstx_idle: got busy=%b ready=%b expected busy=0 ready=1", busy, req_ready);
    end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rstx_flags: got %b expected 0000", flags); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstx_wb: got %b expected 0", wb_valid); end
    rst = 1'b0; alu_ready = 1'b1;
    step();
    checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstx_after: got wb=%b busy=%b expected wb=0 busy=0", wb_valid, busy);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_dst = '0;
    req_setflags = 1'b0; flags_we = 1'b0; flags_wdata = '0;
    alu_res = '0; alu_ready = 1'b0; alu_flag_next = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_timeout();
    test_ext_flags();
    test_flag_conflict();
    test_back_to_back();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL sim_timeout: got no completion expected completion within 100000 time units");
    $fatal(1, "simulation time limit");
  end

endmodule
